// File: rtl/xg_pon_framer_pkg.sv
// Shared types and constants for the XG-PON upstream burst framer.
// The delimiter/trailer defaults match the receive-side frame synchroniser.
package xg_pon_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DELIM,
    ST_PAYLOAD,
    ST_TRAILER,
    ST_DROP,
    ST_GUARD
  } state_t;

  localparam logic [31:0] DEFAULT_DELIMITER = 32'hB2C50FA1;
  localparam logic [31:0] DEFAULT_TRAILER   = 32'h82D6F416;

  // Bytes whose keep bit is clear are zero-filled; keep[i] covers byte i.
  function automatic logic [31:0] mask_bytes(input logic [31:0] data, input logic [3:0] keep);
    logic [31:0] masked;
    masked = '0;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/xg_pon_axis_out_reg.sv
// One-entry AXI-Stream output register; the slot is free when empty or
// being drained, and an unloaded free slot clears back to all-zero.
module xg_pon_axis_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [3:0]  keep,
  input  logic        last,
  input  logic        user,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] tdata,
  output logic [3:0]  tkeep,
  output logic        tlast,
  output logic        tuser,
  output logic        free
);

  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tdata <= '0;
      tkeep <= '0;
      tlast <= 1'b0;
      tuser <= 1'b0;
    end else if (free) begin
      valid <= load;
      tdata <= load ? data : '0;
      tkeep <= load ? keep : '0;
      tlast <= load & last;
      tuser <= load & user;
    end
  end

endmodule

// File: rtl/xg_pon_burst_framer.sv
// Upstream burst framer: preamble, delimiter, payload, trailer.
// Define XG_PON_FRAMER_GUARD_EN to insert GUARD_WORDS idle cycles after each burst.
module xg_pon_burst_framer
  import xg_pon_framer_pkg::*;
#(
  parameter logic [31:0] DELIMITER         = DEFAULT_DELIMITER,
  parameter logic [31:0] TRAILER           = DEFAULT_TRAILER,
  parameter int          MAX_PAYLOAD_WORDS = 2048,
  parameter int          GUARD_WORDS       = 4
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic [31:0] s_axis_TDATA_in,
  input  logic [3:0]  s_axis_TKEEP_in,
  input  logic        s_axis_TLAST_in,
  input  logic        s_axis_TUSER_in,
  input  logic        s_axis_TVALID_in,
  output logic        s_axis_TREADY_out,
  input  logic [31:0] preamble_pattern,
  input  logic [31:0] preamble_duration,
  output logic [31:0] m_axis_TDATA_out,
  output logic [3:0]  m_axis_TKEEP_out,
  output logic        m_axis_TLAST_out,
  output logic        m_axis_TUSER_out,
  output logic        m_axis_TVALID_out,
  input  logic        m_axis_TREADY_in,
  output logic        busy_out,
  output logic        overrun_out,
  output logic        underrun_out
);

  localparam int CW = $clog2(MAX_PAYLOAD_WORDS + 1);

`ifdef XG_PON_FRAMER_GUARD_EN
  localparam int     GW        = $clog2(GUARD_WORDS + 1);
  localparam state_t END_STATE = ST_GUARD;
  logic [GW-1:0] guard_cnt;
`else
  localparam state_t END_STATE = ST_IDLE;
  localparam int unused_guard_words = GUARD_WORDS;
`endif

  state_t        state;
  logic [31:0]   pattern_q;
  logic [31:0]   preamble_left;
  logic [CW-1:0] pay_cnt;
  logic [CW-1:0] pay_cnt_next;
  logic          at_limit;
  logic          drop_pending;
  logic          free;
  logic          load;
  logic [31:0]   ld_data;
  logic [3:0]    ld_keep;
  logic          ld_last;
  logic          ld_user;
  logic          unused_tuser;

  assign unused_tuser      = s_axis_TUSER_in;
  assign pay_cnt_next      = pay_cnt + 1'b1;
  assign at_limit          = (pay_cnt_next == CW'(MAX_PAYLOAD_WORDS));
  assign s_axis_TREADY_out = ((state == ST_PAYLOAD) && free) || (state == ST_DROP);
  assign busy_out          = (state != ST_IDLE);

  // State names the next word to emit; IDLE emits the first word itself so it
  // appears the cycle after the source raises TVALID.
  always_comb begin
    load    = 1'b0;
    ld_data = '0;
    ld_keep = 4'hF;
    ld_last = 1'b0;
    ld_user = 1'b0;
    if (free) begin
      case (state)
        ST_IDLE: begin
          if (s_axis_TVALID_in) begin
            load    = 1'b1;
            ld_user = 1'b1;
            ld_data = (preamble_duration == 32'd0) ? DELIMITER : preamble_pattern;
          end
        end
        ST_PREAMBLE: begin
          load    = 1'b1;
          ld_data = pattern_q;
        end
        ST_DELIM: begin
          load    = 1'b1;
          ld_data = DELIMITER;
        end
        ST_PAYLOAD: begin
          if (s_axis_TVALID_in) begin
            load    = 1'b1;
            ld_data = mask_bytes(s_axis_TDATA_in, s_axis_TKEEP_in);
            ld_keep = s_axis_TKEEP_in;
          end
        end
        ST_TRAILER: begin
          load    = 1'b1;
          ld_data = TRAILER;
          ld_last = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state         <= ST_IDLE;
      pattern_q     <= '0;
      preamble_left <= '0;
      pay_cnt       <= '0;
      drop_pending  <= 1'b0;
      overrun_out   <= 1'b0;
      underrun_out  <= 1'b0;
`ifdef XG_PON_FRAMER_GUARD_EN
      guard_cnt     <= '0;
`endif
    end else begin
      overrun_out  <= 1'b0;
      underrun_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          pay_cnt <= '0;
          if (free && s_axis_TVALID_in) begin
            pattern_q     <= preamble_pattern;
            preamble_left <= preamble_duration - 32'd1;
            if (preamble_duration == 32'd0)      state <= ST_PAYLOAD;
            else if (preamble_duration == 32'd1) state <= ST_DELIM;
            else                                 state <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          if (free) begin
            preamble_left <= preamble_left - 32'd1;
            if (preamble_left == 32'd1) state <= ST_DELIM;
          end
        end
        ST_DELIM: begin
          if (free) state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (free) begin
            if (s_axis_TVALID_in) begin
              pay_cnt <= pay_cnt_next;
              // TLAST on the limit word is a normal end, not an overrun.
              if (s_axis_TLAST_in) begin
                state <= ST_TRAILER;
              end else if (at_limit) begin
                overrun_out  <= 1'b1;
                drop_pending <= 1'b1;
                state        <= ST_TRAILER;
              end
            end else begin
              underrun_out <= 1'b1;
            end
          end
        end
        ST_TRAILER: begin
          if (free) state <= drop_pending ? ST_DROP : END_STATE;
        end
        ST_DROP: begin
          if (s_axis_TVALID_in && s_axis_TLAST_in) begin
            drop_pending <= 1'b0;
            state        <= END_STATE;
          end
        end
`ifdef XG_PON_FRAMER_GUARD_EN
        ST_GUARD: begin
          if (guard_cnt == GW'(GUARD_WORDS - 1)) begin
            guard_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  xg_pon_axis_out_reg u_out_reg (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .load  (load),
    .data  (ld_data),
    .keep  (ld_keep),
    .last  (ld_last),
    .user  (ld_user),
    .ready (m_axis_TREADY_in),
    .valid (m_axis_TVALID_out),
    .tdata (m_axis_TDATA_out),
    .tkeep (m_axis_TKEEP_out),
    .tlast (m_axis_TLAST_out),
    .tuser (m_axis_TUSER_out),
    .free  (free)
  );

endmodule

// File: doc/xg_pon_burst_framer.md
# xg_pon_burst_framer

Upstream burst transmitter for the XG-PON datapath. It wraps a 32-bit AXI-Stream payload into an upstream burst: a programmable preamble, the delimiter, the payload, then a terminating trailer word. It is the transmit counterpart of `xg_PON_frame_sync`, and its output word stream is exactly what that block locks onto. It sits between the upstream payload source and the GT transmit AXIS interface, in the `clk_in` domain.

## Interface
Parameters:
- `DELIMITER`, default 32'hB2C50FA1: burst delimiter word.
- `TRAILER`, default 32'h82D6F416: end-of-burst word.
- `MAX_PAYLOAD_WORDS`, default 2048: payload limit per burst.
- `GUARD_WORDS`, default 4: idle words after each burst. Used only with `XG_PON_FRAMER_GUARD_EN`.

Ports:
- `clk_in` in 1: the single clock.
- `reset_n_in` in 1: asynchronous, active-low reset.
- `s_axis_TDATA_in` in 32, `s_axis_TKEEP_in` in 4, `s_axis_TLAST_in` in 1, `s_axis_TUSER_in` in 1, `s_axis_TVALID_in` in 1: payload input.
- `s_axis_TREADY_out` out 1: payload ready.
- `preamble_pattern` in 32: preamble word.
- `preamble_duration` in 32: number of preamble words.
- `m_axis_TDATA_out` out 32, `m_axis_TKEEP_out` out 4, `m_axis_TLAST_out` out 1, `m_axis_TUSER_out` out 1, `m_axis_TVALID_out` out 1: burst output.
- `m_axis_TREADY_in` in 1: downstream ready.
- `busy_out` out 1: high in every state other than IDLE.
- `overrun_out` out 1: one-cycle pulse on payload truncation.
- `underrun_out` out 1: one-cycle pulse per payload bubble.

## Operation
- FSM states: IDLE, PREAMBLE, DELIM, PAYLOAD, TRAILER, DROP, GUARD.
- **Output slot:** a single output register. A slot is free when `!m_axis_TVALID_out || m_axis_TREADY_in`. The FSM advances only on a free slot. When no word is loaded, TVALID clears.
- **IDLE:**
  - On `s_axis_TVALID_in`, latch `preamble_pattern` and `preamble_duration`. Later changes to these inputs do not affect the current burst.
  - Go to PREAMBLE, or straight to DELIM if the duration is 0. No payload is consumed in IDLE.
- **PREAMBLE:** emit the latched pattern exactly N times, with TKEEP=4'hF. The first word of the burst carries TUSER=1; every other word has TUSER=0. When duration is 0, the DELIM word carries TUSER=1.
- **DELIM:** emit `DELIMITER` once, TKEEP=4'hF, then go to PAYLOAD.
- **PAYLOAD:**
  - `s_axis_TREADY_out = free slot`. Each accepted word is passed through.
  - Bytes with TKEEP=0 are forced to 8'h00. TKEEP bit i covers byte [8i+7:8i].
  - Input TKEEP is forwarded. Input TUSER is ignored. Output TLAST=0.
  - A free slot with no input valid pulses `underrun_out`, and the slot stays empty.
  - The word carrying input TLAST sends the FSM to TRAILER.
  - Payload word counter: width `$clog2(MAX_PAYLOAD_WORDS+1)`, cleared in IDLE.
  - If the counter reaches `MAX_PAYLOAD_WORDS` on a word without TLAST: pulse `overrun_out`, set `drop_pending`, go to TRAILER.
- **TRAILER:** emit `TRAILER` with TKEEP=4'hF and TLAST=1. Next state is DROP if `drop_pending`, otherwise GUARD (macro defined) or IDLE.
- **DROP:** `s_axis_TREADY_out=1`, nothing is emitted. Input words are discarded until the TLAST word, then go to GUARD or IDLE and clear `drop_pending`.
- **Simultaneous events:** TLAST arriving on the limit word counts as a normal end, with no overrun.
- **Reset:** reset mid-burst aborts immediately. No trailer is emitted.

## Timing
- Reset values:
  - All `m_axis_*` outputs 0.
  - `s_axis_TREADY_out`, `busy_out`, `overrun_out`, `underrun_out` all 0.
  - FSM in IDLE, counters 0.
- First preamble word is valid on the cycle after `s_axis_TVALID_in` is sampled high in IDLE.
- Payload latency is 1 cycle, from input accept to `m_axis_TVALID_out`.
- With TREADY held high and no bubbles, a burst occupies exactly N + 1 + P + 1 consecutive valid cycles.
- Backpressure: output data and control stay stable while `m_axis_TVALID_out && !m_axis_TREADY_in`.
- `busy_out` rises with the first preamble word and falls on the cycle the FSM re-enters IDLE.

## Configuration
- `XG_PON_FRAMER_GUARD_EN` defined: after TRAILER (or after DROP completes), GUARD holds `m_axis_TVALID_out=0` and `s_axis_TREADY_out=0` for `GUARD_WORDS` cycles, then returns to IDLE.
- Macro not defined: GUARD is not built. The FSM returns to IDLE directly, and the next burst can start on the following cycle.

## Structure
- Package `xg_pon_framer_pkg` holds:
  - the state enum;
  - default `DELIMITER` and `TRAILER` constants, shared with the receive-side synchroniser configuration;
  - byte-masking function for TKEEP zero-fill.
- Sub-module `xg_pon_axis_out_reg` is the one-entry output register with the free-slot handshake. The FSM lives in the top module.

## Test plan
- **Nominal burst:** pattern=32'hAAAAAAAA, duration=3, payload 5 words ending TKEEP=4'h3, TREADY=1.
  - Expect AA×3 (first with TUSER=1), B2C50FA1, 5 payload words with upper 2 bytes zeroed on the last, then 82D6F416 with TLAST=1. 10 consecutive valid cycles.
- **Zero preamble:** duration=0, 1 payload word. Expect DELIM with TUSER=1, payload, trailer.
- **Backpressure:** TREADY toggles 1,0,0,1 through the burst. Expect no lost or duplicated word, and output stable while stalled.
- **Overrun:** MAX_PAYLOAD_WORDS=4, source sends 7 words. Expect 4 payload words, then trailer, `overrun_out` once, 3 words dropped, `busy_out` low afterwards.
- **Underrun:** source drops TVALID for 2 cycles mid-payload. Expect `underrun_out` high for 2 cycles and a 2-cycle gap in output TVALID, with word order preserved.
- **Reset mid-payload:** assert `reset_n_in`=0 during payload. Expect all outputs 0 immediately, no trailer, and a clean next burst after release.
